spart_rx: RTL and testbench
===========================

SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of metastability flops on rxd; legal values 2..3.
REQ-002 clk  input  1  system clock, 100 MHz; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-004 enable  input  1  16x-oversample baud tick from the SPART baud generator; one-clk pulse.
REQ-005 rxd  input  1  asynchronous RS232 receive line; idle high.
REQ-006 clr_rda  input  1  one-clk read strobe from the bus interface, pulsed on a receive-buffer read.
REQ-007 rx_data  output  8  last correctly framed byte received.
REQ-008 rda  output  1  receive data available; set on a good frame, cleared by clr_rda.
REQ-009 framing_err  output  1  last frame had stop bit = 0.
REQ-010 overrun  output  1  a good frame completed while rda was already 1.

Function
REQ-011 rxd SHALL pass through SYNC_STAGES flops reset to 1; the FSM SHALL use only the synchronized value rxs.
REQ-012 The tick counter (4-bit) and bit counter (3-bit) SHALL advance only on clk edges where enable=1.
REQ-013 The FSM SHALL have exactly five states: IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: on an enable tick with rxs=0, go to START with tick counter=0.
REQ-015 START: at tick count 7 (mid start bit), go to DATA with tick counter=0 and bit counter=0 if rxs=0; otherwise go to IDLE (glitch reject, no flags change).
REQ-016 DATA: at tick count 15, sample rxs into an 8-bit shift register LSB-first (shift = {rxs, shift[7:1]}) and increment the bit counter; after the 8th sample, go to STOP with tick counter=0.
REQ-017 STOP: at tick count 15, sample rxs.
- rxs=1: rx_data<=shift, rda<=1, framing_err<=0, go to IDLE.
- rxs=0: framing_err<=1; rx_data and rda unchanged; go to BREAK.
REQ-018 BREAK: remain until rxs=1 is seen on an enable tick, then go to IDLE; prevents a held-low line from re-triggering as a start bit.
REQ-019 rx_data, rda, framing_err and overrun SHALL be registered; rda SHALL rise on the clk edge after the enable edge that samples the stop bit (latency 1 clk).
REQ-020 On a good frame with rda=1 and clr_rda=0: overrun<=1 and rx_data is overwritten with the new byte.
REQ-021 clr_rda=1 alone SHALL clear rda and overrun on the next edge; framing_err is unaffected.
REQ-022 If clr_rda=1 coincides with good-frame completion: rda=1, rx_data=new byte, overrun<=0.
REQ-023 framing_err SHALL be sticky until the next good frame.
REQ-024 clr_rda SHALL have no effect on the FSM or the counters.

Reset
REQ-025 While rst=0: state=IDLE, counters=0, shift=0, synchronizer flops=1, rx_data=8'h00, rda=0, framing_err=0, overrun=0.
REQ-026 rst asserted mid-frame SHALL abort the frame; after release the block SHALL wait in IDLE for a new falling edge and SHALL NOT output a partial byte.

Verification
REQ-027 Bench enable = one pulse every 4 clk (16 ticks = 64 clk/bit); send 0x45 (bits 1,0,1,0,0,0,1,0 LSB-first) with stop=1 -> rx_data=8'h45, rda=1 one clk after the stop-sample tick, framing_err=0.
REQ-028 rxd low for 5 ticks, then high -> FSM returns to IDLE; rda, rx_data and flags unchanged.
REQ-029 Send 0x5A with stop bit=0, hold rxd low 40 ticks, then high, then send 0x33 -> framing_err=1 and rda=0 after the first frame; FSM stays in BREAK while low; after 0x33: rx_data=8'h33, rda=1, framing_err=0.
REQ-030 Send 0x11 then 0xA5 with no clr_rda -> rx_data=8'hA5, rda=1, overrun=1; pulse clr_rda -> rda=0 and overrun=0 next clk.
REQ-031 Pulse clr_rda on the exact completion edge of a second frame -> rda=1, overrun=0, rx_data=new byte.
REQ-032 Assert rst during bit 4 of a frame, release, continue toggling the remaining bits, then send 0x7E -> rda stays 0 until 0x7E completes; then rx_data=8'h7E.

Source files
------------

// File: rtl/spart_rx.sv
// SPART receiver: 16x-oversampled RS232 deframer with synchronizer, framing-error and overrun flags.
// A completed frame is flagged one clk after its stop-bit sample; the flag registers then update.
module spart_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    input  logic       clr_rda,
    output logic [7:0] rx_data,
    output logic       rda,
    output logic       framing_err,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [3:0]             tick_cnt, tick_nxt;
    logic [2:0]             bit_cnt, bit_nxt;
    logic [7:0]             shift, shift_nxt;
    logic                   good_nxt, bad_nxt, good_q, bad_q;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '1;
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            good_q   <= good_nxt;
            bad_q    <= bad_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        good_nxt  = 1'b0;
        bad_nxt   = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        tick_nxt = '0;
                        if (!rxs) begin
                            state_nxt = DATA;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        shift_nxt = {rxs, shift[7:1]};
                        bit_nxt   = bit_cnt + 3'd1;
                        tick_nxt  = '0;
                        if (bit_cnt == 3'd7)
                            state_nxt = STOP;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        tick_nxt = '0;
                        if (rxs) begin
                            good_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            bad_nxt   = 1'b1;
                            state_nxt = BREAK;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                BREAK: begin
                    if (rxs)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // shift is stable while the FSM sits in IDLE, so it can be latched a clk after the stop sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data     <= 8'h00;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else if (good_q) begin
            rx_data     <= shift;
            rda         <= 1'b1;
            framing_err <= 1'b0;
            overrun     <= rda && !clr_rda;
        end else begin
            if (bad_q)
                framing_err <= 1'b1;
            if (clr_rda) begin
                rda     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: enable every 4 clk, 64 clk per bit, frames aligned to the enable phase.
module tb_spart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       rxd = 1'b1;
    logic       clr_rda = 1'b0;
    logic [7:0] rx_data;
    logic       rda, framing_err, overrun;

    int         tests = 0;
    int         fails = 0;
    logic [1:0] cyc_cnt = '0;
    logic [1:0] en_hist = '0;
    int         rise_cyc;
    logic [1:0] rise_en;
    logic [10:0] snap;

    spart_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rxd(rxd), .clr_rda(clr_rda),
        .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 2'd1;
        en_hist <= {en_hist[0], enable};
    end

    always @(negedge clk) enable <= (cyc_cnt == 2'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line(input logic b, input int n);
        rxd = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rda = 1'b1;
        @(negedge clk);
        clr_rda = 1'b0;
    endtask

    // One 10-bit frame, 640 clk; optional clr_rda pulse and reset window at given clk indices.
    task automatic frame(input logic [7:0] data, input logic stop, input int clr_at, input int rst_at);
        logic [9:0] bits;
        logic       rda_prev;
        bits     = {stop, data, 1'b0};
        rise_cyc = -1;
        rise_en  = 2'b00;
        do @(negedge clk); while (cyc_cnt != 2'd0);
        rda_prev = rda;
        for (int cyc = 0; cyc < 640; cyc++) begin
            rxd     = bits[cyc / 64];
            clr_rda = (cyc == clr_at);
            rst     = !(rst_at >= 0 && cyc >= rst_at && cyc < rst_at + 4);
            if (cyc == rst_at) begin
                #1 snap = {rx_data, rda, framing_err, overrun};
            end
            @(negedge clk);
            if (rda && !rda_prev && rise_cyc < 0) begin
                rise_cyc = cyc;
                rise_en  = en_hist;
            end
            rda_prev = rda;
        end
        clr_rda = 1'b0;
        rst     = 1'b1;
    endtask

    initial begin
        snap = '1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rda", rda, 1'b0);
        check("reset_framing_err", framing_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst = 1'b1;
        line(1'b1, 40);

        frame(8'h45, 1'b1, -1, -1);
        check("good_rx_data", rx_data, 8'h45);
        check("good_rda", rda, 1'b1);
        check("good_framing_err", framing_err, 1'b0);
        check("good_rise_cycle", rise_cyc, 613);
        check("good_rise_after_enable", rise_en, 2'b10);

        line(1'b0, 20);
        line(1'b1, 80);
        check("glitch_rda", rda, 1'b1);
        check("glitch_rx_data", rx_data, 8'h45);
        check("glitch_framing_err", framing_err, 1'b0);
        check("glitch_overrun", overrun, 1'b0);

        pulse_clr();
        check("clr_rda", rda, 1'b0);
        check("clr_framing_err", framing_err, 1'b0);

        frame(8'h5A, 1'b0, -1, -1);
        check("ferr_set", framing_err, 1'b1);
        check("ferr_rda", rda, 1'b0);
        check("ferr_rx_data", rx_data, 8'h45);
        line(1'b0, 160);
        check("break_low_rda", rda, 1'b0);
        line(1'b1, 680);
        check("break_high_rda", rda, 1'b0);
        check("break_ferr_sticky", framing_err, 1'b1);

        frame(8'h33, 1'b1, -1, -1);
        check("after_break_rx_data", rx_data, 8'h33);
        check("after_break_rda", rda, 1'b1);
        check("after_break_ferr", framing_err, 1'b0);

        pulse_clr();
        frame(8'h11, 1'b1, -1, -1);
        check("first_rx_data", rx_data, 8'h11);
        check("first_overrun", overrun, 1'b0);
        frame(8'hA5, 1'b1, -1, -1);
        check("overrun_rx_data", rx_data, 8'hA5);
        check("overrun_rda", rda, 1'b1);
        check("overrun_set", overrun, 1'b1);
        pulse_clr();
        check("overrun_clr_rda", rda, 1'b0);
        check("overrun_clr", overrun, 1'b0);

        frame(8'h3C, 1'b1, -1, -1);
        frame(8'hC3, 1'b1, 613, -1);
        check("coincide_rda", rda, 1'b1);
        check("coincide_overrun", overrun, 1'b0);
        check("coincide_rx_data", rx_data, 8'hC3);

        frame(8'hF0, 1'b1, -1, 340);
        check("async_reset_outputs", snap, 11'h000);
        check("abort_rda", rda, 1'b0);
        check("abort_rx_data", rx_data, 8'h00);
        frame(8'h7E, 1'b1, -1, -1);
        check("post_reset_rx_data", rx_data, 8'h7E);
        check("post_reset_rda", rda, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
